// File: rtl/pixbuf_pkg.sv
// Shared definitions for the pixel buffer arbiter: default widths and the
// per-cycle RAM grant encoding.
package pixbuf_pkg;

    localparam int PIX_ADDR_W = 13;
    localparam int PIX_DATA_W = 5;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2,
        GNT_FORCE = 2'd3
    } grant_e;

    function automatic logic is_write_grant(input grant_e g);
        return (g == GNT_WRITE) || (g == GNT_FORCE);
    endfunction

endpackage

// File: rtl/pixbuf_fifo.sv
// Small synchronous FIFO with wrapping pointers. The head entry is always
// visible on o_head, and a push into an empty FIFO is not visible until the next cycle.
module pixbuf_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage carries no reset; the level and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pixbuf_arbiter.sv
// Shares a single-port pixel RAM between the VGA reader (priority) and buffered
// PPU writes; a stall guard forces a write after MAX_STALL full-FIFO cycles.
module pixbuf_arbiter
    import pixbuf_pkg::*;
#(
    parameter int ADDR_W     = PIX_ADDR_W,
    parameter int DATA_W     = PIX_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STALL  = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_miss,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic                         ram_we,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                   miss_count
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    grant_e            w_grant;

    logic [7:0]        r_stall_cnt;
    logic [7:0]        r_miss_count;
    logic              r_rd_valid;
    logic              r_rd_miss;
    logic [ADDR_W-1:0] r_last_addr;

    assign wr_ready   = !w_full;
    assign w_push     = wr_valid && wr_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_miss    = r_rd_miss;
    assign rd_data    = r_rd_valid ? ram_rdata : '0;
    assign miss_count = r_miss_count;

    pixbuf_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({wr_addr, wr_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // Reset is sampled combinationally so no RAM access leaks out while it is held.
    always_comb begin
        w_grant = GNT_IDLE;
        if (!reset) begin
            w_grant = GNT_IDLE;
        end else if ((r_stall_cnt == 8'(MAX_STALL)) && !w_empty) begin
            w_grant = GNT_FORCE;
        end else if (rd_req) begin
            w_grant = GNT_READ;
        end else if (!w_empty) begin
            w_grant = GNT_WRITE;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = r_last_addr;
        ram_wdata = '0;
        w_pop     = 1'b0;
        case (w_grant)
            GNT_READ: begin
                ram_addr = rd_addr;
            end
            GNT_WRITE, GNT_FORCE: begin
                ram_we    = 1'b1;
                ram_addr  = w_head.addr;
                ram_wdata = w_head.data;
                w_pop     = 1'b1;
            end
            default: begin
                ram_addr = r_last_addr;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_miss_count <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_miss    <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            r_last_addr <= ram_addr;
            r_rd_valid  <= (w_grant == GNT_READ);
            r_rd_miss   <= (w_grant == GNT_FORCE) && rd_req;

            if ((w_grant == GNT_FORCE) && rd_req && (r_miss_count != 8'hFF)) begin
                r_miss_count <= r_miss_count + 8'd1;
            end

            if (is_write_grant(w_grant) || !w_full) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != 8'(MAX_STALL)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end
    end

endmodule
